// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multi-cycle integer multiply/divide unit for the
//                MIPS datapath (MULTU, MULT, DIVU, DIV). Shift-add multiply
//                and restoring divide, one bit per cycle, on unsigned
//                magnitudes with a final sign fix-up. Results land in HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FIXUP = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Counter value on the final RUN iteration
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;

    // Latched operation context
    logic             r_is_div;
    logic             r_neg_q;     // product / quotient sign
    logic             r_neg_r;     // remainder sign
    logic             r_dz;
    logic [WIDTH-1:0] r_operand;   // multiplicand magnitude or divisor magnitude

    // Shared accumulator: {hi,lo} product for multiply, {rem,quot} for divide
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;

    // Result registers
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_by_zero;

    // Accept / operand conditioning
    logic             w_accept;
    logic             w_signed;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Multiply step
    logic [WIDTH:0]   w_add;

    // Divide step
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_sub;

    // Sign fix-up
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // A new op is only taken when the unit is not busy
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_signed = op[0];
    assign w_mag_a  = (w_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign w_mag_b  = (w_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Multiplier LSB sits in acc_lo[0]; add the multiplicand into the upper half
    assign w_add = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});

    // Bring in the next dividend bit; a fitting trial difference is always < divisor,
    // so a WIDTH-bit subtraction is exact in that case
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_operand});
    assign w_sub   = w_shift[WIDTH-1:0] - r_operand;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE,
            c_DONE:  w_next = w_accept ? c_RUN : c_IDLE;
            c_RUN:   w_next = (r_cnt == c_LAST) ? c_FIXUP : c_RUN;
            c_FIXUP: w_next = c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_RUN,
            c_FIXUP: busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-cycle iteration, sign fix-up into HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_is_div      <= 1'b0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_operand     <= '0;
            r_acc_hi      <= '0;
            r_acc_lo      <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            r_neg_r  <= w_signed && operand_a[WIDTH-1];
            r_dz     <= op[1] && (operand_b == '0);
            r_acc_hi <= '0;
            if (op[1]) begin
                // Divide: dividend shifts out of acc_lo while quotient bits shift in
                r_operand <= w_mag_b;
                r_acc_lo  <= w_mag_a;
            end else begin
                // Multiply: multiplier shifts out of acc_lo while product bits shift in
                r_operand <= w_mag_a;
                r_acc_lo  <= w_mag_b;
            end
        end else begin
            case (r_state)
                c_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc_hi <= w_fits ? w_sub : w_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {w_add, r_acc_lo[WIDTH-1:1]};
                    end
                end
                c_FIXUP: begin
                    r_div_by_zero <= r_dz;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_dz) begin
                        // Remainder path already reconstructs operand_a; quotient saturates
                        r_hi <= w_rem_fix;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [1:0] c_MULTU = 2'b00;
    localparam logic [1:0] c_MULT  = 2'b01;
    localparam logic [1:0] c_DIVU  = 2'b10;
    localparam logic [1:0] c_DIV   = 2'b11;
    localparam int         c_LAT   = 33;   // edges from accept edge to done

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to done; optionally pulse a spurious start mid-run
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int pulse_at);
        int          lat;
        int          bcnt;
        logic        held;
        logic [31:0] ph;
        logic [31:0] pl;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        ph = hi; pl = lo; held = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = ~a;          // operands must already be captured
        operand_b = b + 32'd1;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (lat == pulse_at) begin
                start = 1'b1; op = c_MULTU; operand_a = 32'd1; operand_b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (!done && (hi !== ph || lo !== pl)) held = 1'b0;
        end
        start = 1'b0;
        chk({tag, ".lat"},  64'(lat), 64'(c_LAT));
        chk({tag, ".busy"}, 64'(bcnt), 64'(c_LAT));
        chk({tag, ".hi"},   64'(hi), 64'(exp_hi));
        chk({tag, ".lo"},   64'(lo), 64'(exp_lo));
        chk({tag, ".dz"},   64'(div_by_zero), 64'(exp_dz));
        chk({tag, ".held"}, 64'(held), 64'd1);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi",   64'(hi),   64'd0);
        chk("rst.lo",   64'(lo),   64'd0);
        chk("rst.dz",   64'(div_by_zero), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // Consecutive calls start in the done cycle, exercising back-to-back accept
        run_op("multu_max", c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1);
        run_op("mult_neg",  c_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
        run_op("mult_min",  c_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, -1);
        run_op("divu",      c_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, -1);
        run_op("div_neg",   c_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
        run_op("div_ovf",   c_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, -1);
        run_op("divu_z",    c_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, -1);
        run_op("divu_clr",  c_DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0, -1);
        run_op("div_z",     c_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, -1);

        // done lasts one cycle when nothing follows
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("idle_busy",  64'(busy), 64'd0);

        // Spurious start 10 cycles into a run is ignored
        run_op("multu_ign", c_MULTU, 32'd12345, 32'd1000, 32'd0, 32'h00BC5EA8, 1'b0, 10);

        // Reset 15 cycles into a DIV aborts it
        @(negedge clk);
        op = c_DIV; operand_a = 32'hFFFFFFF9; operand_b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.hi",   64'(hi),   64'd0);
        chk("abort.lo",   64'(lo),   64'd0);
        chk("abort.dz",   64'(div_by_zero), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort.quiet", 64'(seen), 64'd0);
        run_op("after_rst", c_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
